// File: rtl/line_buffer_pkg.sv
// Shared types, sizes and helpers for the ping-pong scanline buffer.
package line_buffer_pkg;

  localparam int H_ACTIVE = 640;
  localparam int PIX_W    = 16;
  localparam int ADDR_W   = 10;

  typedef logic [PIX_W-1:0]  rgb565_t;
  typedef logic [ADDR_W-1:0] lb_addr_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    START = 3'd2,
    GUARD = 3'd3,
    LOAD  = 3'd4
  } lb_state_t;

  localparam lb_addr_t LAST_ADDR  = lb_addr_t'(H_ACTIVE - 1);
  localparam lb_addr_t DEPTH_ADDR = lb_addr_t'(H_ACTIVE);

  // Pixel x beyond the active width reads location 0 instead of wrapping.
  function automatic lb_addr_t clamp_addr(input lb_addr_t a);
    return (a < DEPTH_ADDR) ? a : {ADDR_W{1'b0}};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/lb_ram.sv
// One scanline of RGB565 storage: a single write port and a registered read port.
module lb_ram
  import line_buffer_pkg::*;
(
  input  logic     clk,
  input  logic     we_i,
  input  lb_addr_t waddr_i,
  input  rgb565_t  wdata_i,
  input  lb_addr_t raddr_i,
  output rgb565_t  rdata_o
);

  rgb565_t mem_q [H_ACTIVE];
  rgb565_t rdata_q;

  // Write and read share the edge; a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/line_buffer_scanout.sv
// Ping-pong scanline buffer: clears and hands the draw buffer to the sprite loader
// while the display buffer is scanned out. Optional LB_OVERRUN_CNT_EN adds overrun_count.
module line_buffer_scanout
  import line_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  input  logic              blank,
  input  logic [PIX_W-1:0]  bg_color,
  output logic              loader_start,
  input  logic              loader_finish,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  output logic [PIX_W-1:0]  pixel_rgb,
  output logic              overrun,
  input  logic              overrun_clr
`ifdef LB_OVERRUN_CNT_EN
  ,
  output logic [15:0]       overrun_count
`endif
);

  lb_state_t state_q;
  logic      disp_sel_q;
  lb_addr_t  clr_addr_q;
  logic      loader_start_q;
  logic      overrun_q;
  logic      rd_sel_q;
  logic      blank_q;
  rgb565_t   pixel_q;
  rgb565_t   pixel_d;

  logic      line_start_s;
  logic      overrun_set_s;
  logic      draw_sel_s;
  logic      clr_we_s;
  logic      ld_we_s;
  logic      we_s;
  lb_addr_t  waddr_s;
  rgb565_t   wdata_s;
  logic      rd_sel_s;
  lb_addr_t  raddr_s;
  rgb565_t   rd_data0_s;
  rgb565_t   rd_data1_s;
  logic      unused_s;

  assign line_start_s  = (hcount == 11'd0);
  assign overrun_set_s = line_start_s && (state_q != IDLE);
  assign draw_sel_s    = ~disp_sel_q;
  assign unused_s      = ^{vcount, hcount[0]};

  // Draw-buffer write source: clear sweep, or loader pixels once the loader owns the line.
  always_comb begin
    clr_we_s = 1'b0;
    ld_we_s  = 1'b0;
    case (state_q)
      CLEAR:       clr_we_s = 1'b1;
      GUARD, LOAD: ld_we_s  = wr_en && (wr_addr < DEPTH_ADDR);
      default: begin
        clr_we_s = 1'b0;
        ld_we_s  = 1'b0;
      end
    endcase
    if (ld_we_s) begin
      waddr_s = wr_addr;
      wdata_s = wr_data;
    end else begin
      waddr_s = clr_addr_q;
      wdata_s = bg_color;
    end
  end

  assign we_s = clr_we_s | ld_we_s;

  // On the line-start cycle itself, read from the buffer that becomes the display buffer.
  assign rd_sel_s = line_start_s ? ~disp_sel_q : disp_sel_q;
  assign raddr_s  = clamp_addr(hcount[10:1]);

  lb_ram u_ram0 (
    .clk     (clk),
    .we_i    (we_s & ~draw_sel_s),
    .waddr_i (waddr_s),
    .wdata_i (wdata_s),
    .raddr_i (raddr_s),
    .rdata_o (rd_data0_s)
  );

  lb_ram u_ram1 (
    .clk     (clk),
    .we_i    (we_s & draw_sel_s),
    .waddr_i (waddr_s),
    .wdata_i (wdata_s),
    .raddr_i (raddr_s),
    .rdata_o (rd_data1_s)
  );

  // Line sequencer: swap, clear, start pulse, guard, then wait for the loader.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      disp_sel_q     <= 1'b0;
      clr_addr_q     <= {ADDR_W{1'b0}};
      loader_start_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      if (overrun_set_s) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr) begin
        overrun_q <= 1'b0;
      end
      loader_start_q <= 1'b0;
      if (line_start_s) begin
        state_q    <= CLEAR;
        disp_sel_q <= ~disp_sel_q;
        clr_addr_q <= {ADDR_W{1'b0}};
      end else begin
        case (state_q)
          IDLE: state_q <= IDLE;
          CLEAR: begin
            clr_addr_q <= clr_addr_q + 10'd1;
            if (clr_addr_q == LAST_ADDR) begin
              state_q        <= START;
              loader_start_q <= 1'b1;
            end
          end
          START: state_q <= GUARD;
          GUARD: state_q <= LOAD;
          LOAD: begin
            if (loader_finish) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Output mux uses the select and blank that travelled with the read address.
  always_comb begin
    if (blank_q) begin
      pixel_d = {PIX_W{1'b0}};
    end else if (rd_sel_q) begin
      pixel_d = rd_data1_s;
    end else begin
      pixel_d = rd_data0_s;
    end
  end

  // Scanout pipeline: RAM read stage, then registered pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_sel_q <= 1'b0;
      blank_q  <= 1'b1;
      pixel_q  <= {PIX_W{1'b0}};
    end else begin
      rd_sel_q <= rd_sel_s;
      blank_q  <= blank;
      pixel_q  <= pixel_d;
    end
  end

`ifdef LB_OVERRUN_CNT_EN
  logic [15:0] ovr_cnt_q;

  // A clear coinciding with a new overrun leaves that overrun counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_cnt_q <= 16'd0;
    end else if (overrun_set_s) begin
      ovr_cnt_q <= overrun_clr ? 16'd1 : sat_inc16(ovr_cnt_q);
    end else if (overrun_clr) begin
      ovr_cnt_q <= 16'd0;
    end
  end

  assign overrun_count = ovr_cnt_q;
`endif

  assign loader_start = loader_start_q;
  assign overrun      = overrun_q;
  assign pixel_rgb    = pixel_q;

endmodule

// File: tb/tb_line_buffer_scanout.sv
// Self-checking bench for line_buffer_scanout: per-line table, random loader traffic
// against a timeline-based reference model, plus hand-written corner sequences.
module tb_line_buffer_scanout;

  localparam int H_ACTIVE  = 640;
  localparam int LINE_CLKS = 1600;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        blank;
  logic [15:0] bg_color;
  logic        loader_start;
  logic        loader_finish;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data;
  logic [15:0] pixel_rgb;
  logic        overrun;
  logic        overrun_clr;
`ifdef LB_OVERRUN_CNT_EN
  logic [15:0] overrun_count;
`endif

  always #5 clk = ~clk;

  line_buffer_scanout dut (
    .clk           (clk),
    .reset         (reset),
    .hcount        (hcount),
    .vcount        (vcount),
    .blank         (blank),
    .bg_color      (bg_color),
    .loader_start  (loader_start),
    .loader_finish (loader_finish),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .pixel_rgb     (pixel_rgb),
    .overrun       (overrun),
    .overrun_clr   (overrun_clr)
`ifdef LB_OVERRUN_CNT_EN
    ,
    .overrun_count (overrun_count)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // stimulus configuration
  int          hc = 0;
  int          line_no = 0;
  int          cfg_fin = 50;
  int          cfg_clr_at = -1;
  bit          cfg_blank = 1'b0;
  bit          cfg_script = 1'b0;
  logic [15:0] cfg_bg = 16'h0000;
  bit          blank_pulse = 1'b0;
  int          ld_age = -1;
  bit          saw_start = 1'b0;

  // reference model: two line images, which one is shown, and a time since line start
  typedef enum int {P_IDLE, P_CLEAR, P_START, P_GUARD, P_LOAD} phase_e;
  logic [15:0] mbuf [2][H_ACTIVE];
  bit          mval [2][H_ACTIVE];
  int          t_now = 0;
  bit          m_active = 1'b0;
  int          m_ls_t = 0;
  bit          m_disp = 1'b0;
  bit          m_ovr = 1'b0;
  int          m_cnt = 0;
  bit          pipe_known = 1'b0;
  logic [15:0] pipe_val = 16'h0000;
  bit          exp_pix_known = 1'b0;
  logic [15:0] exp_pix = 16'h0000;
  bit          exp_ls = 1'b0;

  typedef struct {
    int fin;
    int clr_at;
    bit blank_all;
    bit exp_ovr;
  } line_rec_t;
  line_rec_t tbl [8];

  function automatic phase_e phase_at(int t);
    int d;
    if (!m_active) return P_IDLE;
    d = t - m_ls_t;
    if (d <= H_ACTIVE)     return P_CLEAR;
    if (d == H_ACTIVE + 1) return P_START;
    if (d == H_ACTIVE + 2) return P_GUARD;
    return P_LOAD;
  endfunction

  function automatic void mwrite(bit b, int a, logic [15:0] d);
    mbuf[b][a] = d;
    mval[b][a] = 1'b1;
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0d hc=%0d: got %h expected %h", name, t_now, hc, act, exp);
  endtask

  task automatic model_cycle();
    phase_e      ph;
    bit          rs;
    int          ra;
    bit          known;
    logic [15:0] val;
    if (reset) begin
      m_active      = 1'b0;
      m_disp        = 1'b0;
      m_ovr         = 1'b0;
      m_cnt         = 0;
      exp_pix_known = 1'b1;
      exp_pix       = 16'h0000;
      pipe_known    = 1'b1;
      pipe_val      = 16'h0000;
    end else begin
      ph = phase_at(t_now);
      rs = (hcount == 11'd0) ? ~m_disp : m_disp;
      ra = int'(hcount) / 2;
      if (ra >= H_ACTIVE) ra = 0;
      known = blank || mval[rs][ra];
      val   = blank ? 16'h0000 : mbuf[rs][ra];
      exp_pix_known = pipe_known;
      exp_pix       = pipe_val;
      pipe_known    = known;
      pipe_val      = val;
      if (ph == P_CLEAR) mwrite(~m_disp, t_now - m_ls_t - 1, bg_color);
      if ((ph == P_GUARD || ph == P_LOAD) && wr_en && int'(wr_addr) < H_ACTIVE)
        mwrite(~m_disp, int'(wr_addr), wr_data);
      if (hcount == 11'd0 && ph != P_IDLE) begin
        m_ovr = 1'b1;
        m_cnt = overrun_clr ? 1 : ((m_cnt < 65535) ? m_cnt + 1 : m_cnt);
      end else if (overrun_clr) begin
        m_ovr = 1'b0;
        m_cnt = 0;
      end
      if (ph == P_LOAD && loader_finish) m_active = 1'b0;
      if (hcount == 11'd0) begin
        m_disp   = ~m_disp;
        m_ls_t   = t_now;
        m_active = 1'b1;
      end
    end
    exp_ls = (phase_at(t_now + 1) == P_START);
    t_now++;
  endtask

  task automatic drive_inputs();
    if (saw_start) ld_age = 0;
    else if (ld_age >= 0) ld_age++;
    hcount        = 11'(hc);
    vcount        = 10'(line_no);
    blank         = cfg_blank || blank_pulse || (hc >= 2 * H_ACTIVE);
    bg_color      = cfg_bg;
    overrun_clr   = (hc == cfg_clr_at);
    loader_finish = (ld_age < 2) || (ld_age >= cfg_fin + 2);
    if (cfg_script) begin
      wr_en = 1'b0; wr_addr = 10'd0; wr_data = 16'h0000;
      if (hc == 10)     begin wr_en = 1'b1; wr_addr = 10'd5;   wr_data = 16'h07E0; end
      if (ld_age == 12) begin wr_en = 1'b1; wr_addr = 10'd100; wr_data = 16'hF800; end
      if (ld_age == 22) begin wr_en = 1'b1; wr_addr = 10'd700; wr_data = 16'h1234; end
    end else begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 10'($urandom_range(0, 699));
      wr_data = 16'($urandom);
    end
    if (ld_age >= cfg_fin + 2) ld_age = -1;
  endtask

  task automatic step();
    drive_inputs();
    @(posedge clk);
    model_cycle();
    #1;
    check("loader_start", {15'd0, loader_start}, {15'd0, exp_ls});
    check("overrun", {15'd0, overrun}, {15'd0, m_ovr});
    if (exp_pix_known) check("pixel_rgb", pixel_rgb, exp_pix);
`ifdef LB_OVERRUN_CNT_EN
    check("overrun_count", overrun_count, 16'(m_cnt));
`endif
    saw_start = loader_start;
    hc = (hc + 1) % LINE_CLKS;
  endtask

  task automatic run_line();
    for (int i = 0; i < LINE_CLKS; i++) step();
    line_no++;
  endtask

  initial begin
    tbl[0] = '{fin: 50,   clr_at: -1, blank_all: 1'b0, exp_ovr: 1'b0};
    tbl[1] = '{fin: 50,   clr_at: -1, blank_all: 1'b0, exp_ovr: 1'b0};
    tbl[2] = '{fin: 1200, clr_at: -1, blank_all: 1'b0, exp_ovr: 1'b0};
    tbl[3] = '{fin: 50,   clr_at: 10, blank_all: 1'b0, exp_ovr: 1'b0};
    tbl[4] = '{fin: 1200, clr_at: -1, blank_all: 1'b0, exp_ovr: 1'b0};
    tbl[5] = '{fin: 50,   clr_at: 0,  blank_all: 1'b0, exp_ovr: 1'b1};
    tbl[6] = '{fin: 50,   clr_at: 5,  blank_all: 1'b1, exp_ovr: 1'b0};
    tbl[7] = '{fin: 300,  clr_at: -1, blank_all: 1'b0, exp_ovr: 1'b0};

    reset = 1'b1;
    hc    = 1590;
    for (int i = 0; i < 5; i++) step();
    reset = 1'b0;
    for (int i = 0; i < 20 && hc != 0; i++) step();

    // random loader traffic, one table record per line
    for (int i = 0; i < 8; i++) begin
      cfg_fin    = tbl[i].fin;
      cfg_clr_at = tbl[i].clr_at;
      cfg_blank  = tbl[i].blank_all;
      cfg_script = 1'b0;
      cfg_bg     = 16'($urandom);
      run_line();
      check("overrun_eol", {15'd0, overrun}, {15'd0, tbl[i].exp_ovr});
    end

    // line A: known background, one loader pixel, ignored writes in CLEAR and at x=700
    cfg_fin = 50; cfg_clr_at = -1; cfg_blank = 1'b0; cfg_script = 1'b1; cfg_bg = 16'h001F;
    run_line();

    // line B: show line A, with a one-cycle blank at hcount 400
    cfg_bg = 16'hAAAA;
    for (int h = 0; h < LINE_CLKS; h++) begin
      blank_pulse = (h == 400);
      step();
      if (h == 201 || h == 202) check("px_write", pixel_rgb, 16'hF800);
      if (h == 200 || h == 203 || h == 12 || h == 402) check("px_bg", pixel_rgb, 16'h001F);
      if (h == 401) check("px_blank", pixel_rgb, 16'h0000);
      if (h == 640) check("start_pulse", {15'd0, loader_start}, 16'h0001);
      if (h == 639 || h == 641) check("start_quiet", {15'd0, loader_start}, 16'h0000);
    end
    blank_pulse = 1'b0;
    line_no++;

    // line C: reset while the clear is at address 300
    cfg_bg = 16'h001F;
    for (int h = 0; h < LINE_CLKS; h++) begin
      reset = (h >= 301 && h <= 305);
      step();
      if (h == 301) begin
        check("rst_start", {15'd0, loader_start}, 16'h0000);
        check("rst_pixel", pixel_rgb, 16'h0000);
      end
      if (h == 640) check("rst_no_start", {15'd0, loader_start}, 16'h0000);
    end
    reset = 1'b0;
    line_no++;

    // line D: full clear after the reset
    cfg_bg = 16'h07E0;
    for (int h = 0; h < LINE_CLKS; h++) begin
      step();
      if (h == 0) check("rst_no_ovr", {15'd0, overrun}, 16'h0000);
      if (h == 640) check("post_rst_start", {15'd0, loader_start}, 16'h0001);
    end
    line_no++;

    // line E: show line D
    cfg_bg = 16'h5555;
    for (int h = 0; h < LINE_CLKS; h++) begin
      step();
      if (h == 2 || h == 1279) check("post_rst_bg", pixel_rgb, 16'h07E0);
      if (h == 202) check("post_rst_write", pixel_rgb, 16'hF800);
    end
    line_no++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
